bvnb_op_scheduler: RTL and testbench
====================================

// Module: bvnb_op_scheduler
// PURPOSE
//  Shares one BlockingVsNonBlocking datapath (A[3:0], B[3:0], go -> Y[7:0]) among NREQ requesters.
//  - Round-robin grant.
//  - Drives operands and a one-cycle go pulse, waits a fixed latency, then captures Y.
//  - Returns the result on a valid/ready response channel tagged with the requester id.
//  - Sits between the requesting units and the single datapath instance; it is the only driver of A/B/go.
// PARAMETERS
//  NREQ   2   number of requesters (>=2)
//  W_IN   4   operand width (A, B)
//  W_OUT  8   result width (Y)
//  LAT    2   cycles from the go-high cycle until Y is valid (>=1)
// PORTS
//  clk        in   1             rising-edge clock
//  rst_n      in   1             synchronous active-low reset
//  req_valid  in   NREQ          requester i has an operand pair
//  req_ready  out  NREQ          one-hot grant, combinational in IDLE; request accepted when valid&ready
//  req_a      in   NREQ*W_IN     operand A, requester i at [i*W_IN +: W_IN]
//  req_b      in   NREQ*W_IN     operand B, same packing
//  rsp_valid  out  1             result available
//  rsp_ready  in   1             consumer accepts result
//  rsp_data   out  W_OUT         captured Y
//  rsp_id     out  $clog2(NREQ)  index of the requester that owns rsp_data
//  dp_a       out  W_IN          to datapath A (registered)
//  dp_b       out  W_IN          to datapath B (registered)
//  dp_go      out  1             to datapath go (registered, one-cycle pulse)
//  dp_y       in   W_OUT         from datapath Y
//  busy       out  1             high in every state except IDLE
// BEHAVIOUR
//  Reset (rst_n=0 at posedge):
//  - state=IDLE; rr_ptr=0; cnt=0.
//  - dp_a, dp_b, dp_go, rsp_valid, rsp_data, rsp_id = 0.
//  - Any in-flight op is dropped and no response is emitted.
//  - req_ready=0 while rst_n=0.
//  FSM:
//  - IDLE: if any req_valid, grant the first valid index at or after rr_ptr (wrapping NREQ-1 -> 0).
//    - req_ready[g]=1 for that cycle only.
//    - Latch dp_a/dp_b <= req_a/req_b[g]; id <= g; rr_ptr <= (g+1) mod NREQ.
//    - Next state ISSUE. With no req_valid, hold all outputs.
//  - ISSUE: dp_go=1 for exactly this cycle; cnt <= LAT-1; next state WAIT.
//  - WAIT: dp_go=0; dp_a/dp_b held stable. If cnt==0: rsp_data <= dp_y, rsp_id <= id, rsp_valid <= 1,
//    next state RESP; else cnt <= cnt-1.
//  - RESP: hold rsp_valid/rsp_data/rsp_id stable until rsp_valid & rsp_ready.
//    On that cycle rsp_valid <= 0 and next state IDLE.
//  Timing:
//  - Latency: accept at cycle t -> dp_go high at t+1 -> rsp_valid high at t+2+LAT (rsp_ready held high).
//  - Minimum op spacing is LAT+3 cycles.
//  - dp_go always spends >=1 low cycle between pulses, because the datapath acts on the go rising edge.
//  Boundaries:
//  - Simultaneous requests: only one granted per op; a requester never waits more than NREQ-1 grants.
//  - req_ready never asserts outside IDLE; the scheduler ignores req_valid/req_a/req_b changes during ISSUE/WAIT/RESP.
//  - rsp_ready low indefinitely: stall in RESP with no further grant and dp_go=0.
//  - rr_ptr wraps modulo NREQ; a grant to NREQ-1 sets rr_ptr=0.
//  - Reset asserted in any state takes effect at the next posedge, per the reset rule above.
//  - Widths: rsp_data is exactly W_OUT bits of dp_y, with no truncation or extension.
// STRUCTURE
//  - bvnb_pkg: state enum (IDLE, ISSUE, WAIT, RESP), width localparams, id width function.
//  - Sub-module rr_arbiter #(NREQ): inputs req, ptr; outputs one-hot gnt, gnt_idx (combinational).
//  - Top holds the FSM, latency counter, operand and response registers.
// TESTING (bench datapath model: Y = A*B registered LAT cycles after go rises)
//  1 Reset: rst_n=0 for 2 cycles mid-WAIT -> all outputs 0, state IDLE, no rsp_valid afterwards.
//  2 Single op: req0 A=1, B=3, rsp_ready=1 -> dp_go pulse 1 cycle at t+1; rsp_valid at t+4 with data=3, id=0.
//  3 Contention: req0 (2,5) and req1 (4,4) held valid -> grant order 0,1,0,1; data 10,16; ids alternate.
//  4 Backpressure: rsp_ready=0 for 10 cycles -> rsp held stable; no req_ready; dp_go stays 0.
//  5 Wrap/fairness: NREQ=3, only req2 then all three valid -> grants 2,0,1,2.
//  6 Edge values: A=15, B=15 -> data=225. Go gap check: dp_go never high on 2 consecutive cycles across
//    back-to-back ops.

Source files
------------

// File: rtl/bvnb_op_scheduler_pkg.sv
// Shared types for the BVNB operation scheduler.
// State encoding, default widths and the id width helper.
package bvnb_op_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam int NREQ_D  = 2;
  localparam int W_IN_D  = 4;
  localparam int W_OUT_D = 8;
  localparam int LAT_D   = 2;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bvnb_op_scheduler_if.sv
// Request, response and datapath bundle of the scheduler.
// master = requesters/consumer/datapath side, slave = scheduler.
interface bvnb_op_scheduler_if
  import bvnb_op_scheduler_pkg::*;
#(
  parameter int NREQ  = NREQ_D,
  parameter int W_IN  = W_IN_D,
  parameter int W_OUT = W_OUT_D
) ();

  localparam int IDW = id_w(NREQ);

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*W_IN-1:0] req_a;
  logic [NREQ*W_IN-1:0] req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [W_OUT-1:0]     rsp_data;
  logic [IDW-1:0]       rsp_id;
  logic [W_IN-1:0]      dp_a;
  logic [W_IN-1:0]      dp_b;
  logic                 dp_go;
  logic [W_OUT-1:0]     dp_y;
  logic                 busy;

  modport master (
    output req_valid,
    output req_a,
    output req_b,
    output rsp_ready,
    output dp_y,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data,
    input  rsp_id,
    input  dp_a,
    input  dp_b,
    input  dp_go,
    input  busy
  );

  modport slave (
    input  req_valid,
    input  req_a,
    input  req_b,
    input  rsp_ready,
    input  dp_y,
    output req_ready,
    output rsp_valid,
    output rsp_data,
    output rsp_id,
    output dp_a,
    output dp_b,
    output dp_go,
    output busy
  );

endinterface

// File: rtl/bvnb_op_scheduler_rr_arbiter.sv
// Round-robin arbiter: first valid request at or after ptr.
// Purely combinational; the owner advances ptr.
module rr_arbiter
  import bvnb_op_scheduler_pkg::*;
#(
  parameter int NREQ = NREQ_D,
  localparam int IDW = id_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx
);

  logic           hit;
  logic [IDW-1:0] k;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    hit     = 1'b0;
    k       = '0;
    for (int i = 0; i < NREQ; i++) begin
      k = IDW'((int'(ptr) + i) % NREQ);
      if (!hit && req[k]) begin
        hit     = 1'b1;
        gnt[k]  = 1'b1;
        gnt_idx = k;
      end
    end
  end

endmodule

// File: rtl/bvnb_op_scheduler.sv
// Shares one BVNB datapath among NREQ requesters.
// Round-robin grant, go pulse, fixed-latency capture, tagged response.
module bvnb_op_scheduler
  import bvnb_op_scheduler_pkg::*;
#(
  parameter int NREQ  = NREQ_D,
  parameter int W_IN  = W_IN_D,
  parameter int W_OUT = W_OUT_D,
  parameter int LAT   = LAT_D
) (
  input logic clk,
  input logic rst_n,
  bvnb_op_scheduler_if.slave bus
);

  localparam int IDW = id_w(NREQ);
  localparam int CW  = (LAT > 1) ? $clog2(LAT) : 1;

  state_t state_q;
  state_t state_d;

  logic [IDW-1:0]   rr_q;
  logic [IDW-1:0]   id_q;
  logic [CW-1:0]    cnt_q;
  logic [W_IN-1:0]  a_q;
  logic [W_IN-1:0]  b_q;
  logic             go_q;
  logic             rv_q;
  logic [W_OUT-1:0] rd_q;
  logic [IDW-1:0]   rid_q;

  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gnt_idx;
  logic             any_req;
  logic             accept;
  logic             issue;
  logic             capture;
  logic             hs;

  assign any_req = |bus.req_valid;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .req     (bus.req_valid),
    .ptr     (rr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (cnt_q == '0) state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    accept  = 1'b0;
    issue   = 1'b0;
    capture = 1'b0;
    hs      = 1'b0;
    unique case (1'b1)
      (state_q == IDLE):  accept  = any_req;
      (state_q == ISSUE): issue   = 1'b1;
      (state_q == WAIT):  capture = (cnt_q == '0);
      (state_q == RESP):  hs      = bus.rsp_ready;
      default: ;
    endcase
  end

  // Operand, counter and response registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_q  <= '0;
      id_q  <= '0;
      cnt_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      go_q  <= 1'b0;
      rv_q  <= 1'b0;
      rd_q  <= '0;
      rid_q <= '0;
    end else begin
      go_q <= accept;
      if (accept) begin
        a_q  <= bus.req_a[gnt_idx*W_IN +: W_IN];
        b_q  <= bus.req_b[gnt_idx*W_IN +: W_IN];
        id_q <= gnt_idx;
        rr_q <= (gnt_idx == IDW'(NREQ - 1)) ?
                '0 : gnt_idx + 1'b1;
      end
      if (issue) begin
        cnt_q <= CW'(LAT - 1);
      end else if (state_q == WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (capture) begin
        rd_q  <= bus.dp_y;
        rid_q <= id_q;
        rv_q  <= 1'b1;
      end else if (hs) begin
        rv_q <= 1'b0;
      end
    end
  end

  // Grant is only offered while idle and out of reset
  assign bus.req_ready = (state_q == IDLE && rst_n) ? gnt : '0;
  assign bus.dp_a      = a_q;
  assign bus.dp_b      = b_q;
  assign bus.dp_go     = go_q;
  assign bus.rsp_valid = rv_q;
  assign bus.rsp_data  = rd_q;
  assign bus.rsp_id    = rid_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_bvnb_op_scheduler.sv
// Bench for bvnb_op_scheduler: directed scenarios plus random traffic.
// A transaction-timeline model checks every output on every cycle.
module tb_bvnb_op_scheduler;

  localparam int NREQ  = 3;
  localparam int W_IN  = 4;
  localparam int W_OUT = 8;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  bvnb_op_scheduler_if #(
    .NREQ(NREQ), .W_IN(W_IN), .W_OUT(W_OUT)
  ) bus ();

  bvnb_op_scheduler #(
    .NREQ(NREQ), .W_IN(W_IN), .W_OUT(W_OUT), .LAT(LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Datapath: Y = A*B, LAT registers after go rises
  logic [W_OUT-1:0] ys [LAT] = '{default: '0};
  logic             gp = 1'b0;

  always @(posedge clk) begin
    gp <= bus.dp_go;
    if (bus.dp_go && !gp)
      ys[0] <= W_OUT'(bus.dp_a) * W_OUT'(bus.dp_b);
    for (int i = 1; i < LAT; i++) ys[i] <= ys[i-1];
  end

  assign bus.dp_y = ys[LAT-1];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic int m_grant(input int rr,
                                 input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++)
      if (v[(rr + i) % NREQ]) return (rr + i) % NREQ;
    return -1;
  endfunction

  // Model state: idle or an op accepted at cycle m_t
  bit mv = 0;
  bit m_idle = 1;
  int m_t, m_rr, m_id, m_a, m_b, m_rd, m_rid;

  // Observed events for the literal checks
  int glog[$];
  int rlog_d[$];
  int rlog_id[$];
  int n_rv_rise = 0;
  int n_go_dbl = 0;
  int min_gap = 1000;
  int last_go = -1000;
  int acc_cyc, go_cyc, rv_cyc;
  bit prev_go = 0;
  bit prev_rv = 0;

  always @(negedge clk) begin : mdl
    int g, d;
    bit e_rv;
    g = m_idle ? m_grant(m_rr, bus.req_valid) : -1;
    d = cyc - m_t;
    e_rv = !m_idle && d >= 2 + LAT;
    if (mv) begin
      for (int i = 0; i < NREQ; i++)
        if (bus.req_ready[i]) begin
          glog.push_back(i);
          acc_cyc = cyc;
        end
      if (bus.dp_go) begin
        if (prev_go) n_go_dbl++;
        if (cyc - last_go < min_gap) min_gap = cyc - last_go;
        last_go = cyc;
        go_cyc = cyc;
      end
      if (bus.rsp_valid && !prev_rv) begin
        n_rv_rise++;
        rv_cyc = cyc;
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        rlog_d.push_back(int'(bus.rsp_data));
        rlog_id.push_back(int'(bus.rsp_id));
      end
      prev_go = bus.dp_go;
      prev_rv = bus.rsp_valid;
      chk("req_ready", int'(bus.req_ready),
          (rst_n && g >= 0) ? (1 << g) : 0);
      chk("busy", int'(bus.busy), m_idle ? 0 : 1);
      chk("dp_go", int'(bus.dp_go), int'(!m_idle && d == 1));
      chk("rsp_valid", int'(bus.rsp_valid), int'(e_rv));
      chk("rsp_data", int'(bus.rsp_data), m_rd);
      chk("rsp_id", int'(bus.rsp_id), m_rid);
      chk("dp_a", int'(bus.dp_a), m_a);
      chk("dp_b", int'(bus.dp_b), m_b);
    end
    if (!rst_n) begin
      mv = 1;
      m_idle = 1;
      m_t = 0;
      m_rr = 0;
      m_a = 0;
      m_b = 0;
      m_rd = 0;
      m_rid = 0;
    end else if (mv) begin
      if (m_idle) begin
        if (g >= 0) begin
          m_idle = 0;
          m_t = cyc;
          m_id = g;
          m_a = int'(bus.req_a[g*W_IN +: W_IN]);
          m_b = int'(bus.req_b[g*W_IN +: W_IN]);
          m_rr = (g + 1) % NREQ;
        end
      end else begin
        if (d == 1 + LAT) begin
          m_rd = (m_a * m_b) % (1 << W_OUT);
          m_rid = m_id;
        end
        if (e_rv && bus.rsp_ready) m_idle = 1;
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit v,
                         input int a, input int b);
    bus.req_valid[i] = v;
    bus.req_a[i*W_IN +: W_IN] = W_IN'(a);
    bus.req_b[i*W_IN +: W_IN] = W_IN'(b);
  endtask

  task automatic wait_grant(input int i, input string nm);
    bit ok = 0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      #1;
      if (bus.req_ready[i]) ok = 1;
    end
    chk(nm, int'(ok), 1);
    step();
  endtask

  task automatic wait_glog(input int n, input string nm);
    bit ok = 0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      #1;
      if (glog.size() >= n) ok = 1;
    end
    chk(nm, int'(ok), 1);
    step();
  endtask

  task automatic wait_rsp(input int n, input string nm);
    bit ok = 0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      #1;
      if (rlog_d.size() >= n) ok = 1;
    end
    chk(nm, int'(ok), 1);
    step();
  endtask

  task automatic clear_logs();
    glog.delete();
    rlog_d.delete();
    rlog_id.delete();
  endtask

  function automatic int qat(input int q[$], input int i);
    return (q.size() > i) ? q[i] : -1;
  endfunction

  initial begin : stim
    int eg[4];
    int ed[4];
    int n0;
    int bad;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    // Single op: 1*3 from requester 0
    clear_logs();
    set_req(0, 1, 1, 3);
    wait_grant(0, "t2_grant_timeout");
    set_req(0, 0, 0, 0);
    wait_rsp(1, "t2_rsp_timeout");
    chk("t2_data", qat(rlog_d, 0), 3);
    chk("t2_id", qat(rlog_id, 0), 0);
    chk("t2_go_latency", go_cyc - acc_cyc, 1);
    chk("t2_rsp_latency", rv_cyc - acc_cyc, 2 + LAT);

    // Reset for two cycles while waiting on the datapath
    set_req(1, 1, 7, 9);
    wait_grant(1, "t1_grant_timeout");
    set_req(1, 0, 0, 0);
    step();
    chk("t1_busy_before", int'(bus.busy), 1);
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    chk("t1_busy", int'(bus.busy), 0);
    chk("t1_go", int'(bus.dp_go), 0);
    chk("t1_rsp_valid", int'(bus.rsp_valid), 0);
    chk("t1_rsp_data", int'(bus.rsp_data), 0);
    chk("t1_rsp_id", int'(bus.rsp_id), 0);
    chk("t1_dp_a", int'(bus.dp_a), 0);
    chk("t1_dp_b", int'(bus.dp_b), 0);
    n0 = n_rv_rise;
    repeat (10) step();
    chk("t1_no_rsp_after_reset", n_rv_rise, n0);

    // Contention between requesters 0 and 1
    clear_logs();
    set_req(0, 1, 2, 5);
    set_req(1, 1, 4, 4);
    wait_glog(4, "t3_grant_timeout");
    set_req(0, 0, 0, 0);
    set_req(1, 0, 0, 0);
    wait_rsp(4, "t3_rsp_timeout");
    eg = '{0, 1, 0, 1};
    ed = '{10, 16, 10, 16};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_grant%0d", i), qat(glog, i), eg[i]);
      chk($sformatf("t3_data%0d", i), qat(rlog_d, i), ed[i]);
      chk($sformatf("t3_id%0d", i), qat(rlog_id, i), eg[i]);
    end

    // Backpressure: response held, no grant, no go
    clear_logs();
    bus.rsp_ready = 1'b0;
    set_req(2, 1, 6, 7);
    wait_grant(2, "t4_grant_timeout");
    set_req(2, 0, 0, 0);
    bad = 1;
    for (int k = 0; k < 20 && bad != 0; k++) begin
      @(negedge clk);
      #1;
      if (bus.rsp_valid) bad = 0;
    end
    chk("t4_rsp_timeout", bad, 0);
    set_req(0, 1, 1, 2);
    set_req(1, 1, 3, 3);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      if (bus.req_ready != '0 || bus.dp_go ||
          !bus.rsp_valid || bus.rsp_data != 8'd42 ||
          bus.rsp_id != 2'd2) bad++;
    end
    chk("t4_stall_stable", bad, 0);
    step();
    bus.rsp_ready = 1'b1;
    wait_grant(0, "t4_regrant_timeout");
    set_req(0, 0, 0, 0);
    set_req(1, 0, 0, 0);
    wait_rsp(2, "t4_rsp2_timeout");
    chk("t4_data0", qat(rlog_d, 0), 42);
    chk("t4_id0", qat(rlog_id, 0), 2);
    chk("t4_data1", qat(rlog_d, 1), 2);
    chk("t4_grant1", qat(glog, 1), 0);

    // Wrap and fairness: req2 alone, then all three
    clear_logs();
    set_req(2, 1, 3, 5);
    wait_grant(2, "t5_grant_timeout");
    set_req(0, 1, 1, 1);
    set_req(1, 1, 2, 2);
    set_req(2, 1, 3, 3);
    wait_glog(4, "t5_grants_timeout");
    for (int i = 0; i < NREQ; i++) set_req(i, 0, 0, 0);
    wait_rsp(4, "t5_rsp_timeout");
    eg = '{2, 0, 1, 2};
    ed = '{15, 1, 4, 9};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t5_grant%0d", i), qat(glog, i), eg[i]);
      chk($sformatf("t5_data%0d", i), qat(rlog_d, i), ed[i]);
    end

    // Edge operands, back to back
    clear_logs();
    set_req(0, 1, 15, 15);
    set_req(1, 1, 15, 14);
    wait_glog(2, "t6_grant_timeout");
    set_req(0, 0, 0, 0);
    set_req(1, 0, 0, 0);
    wait_rsp(2, "t6_rsp_timeout");
    chk("t6_data0", qat(rlog_d, 0), 225);
    chk("t6_data1", qat(rlog_d, 1), 210);
    chk("t6_go_min_gap", min_gap, LAT + 3);

    // Random traffic with occasional resets
    for (int k = 0; k < 1500; k++) begin
      bus.req_valid = NREQ'($urandom_range(0, 7));
      bus.req_a = (NREQ*W_IN)'($urandom);
      bus.req_b = (NREQ*W_IN)'($urandom);
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 199) != 0);
      step();
    end
    rst_n = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    repeat (20) step();
    chk("go_never_double", n_go_dbl, 0);
    chk("drained_idle", int'(bus.busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
